irq_ctrl: RTL
=============

# irq_ctrl

Memory-mapped interrupt controller that drives the `interrupt` input of the 3-stage pipelined core (`main`). It edge-detects external interrupt sources, owns a free-running machine timer with a compare register, and latches pending requests under an enable mask. It issues a single-cycle `interrupt` pulse toward the core, then holds off further pulses until software completes the handled request through the CLAIM register. The core's load/store path reaches it as a word-addressed peripheral.

## Interface
- NUM_SRC, 4, number of external sources (1..31); the timer is source ID NUM_SRC
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SRC  external request lines, synchronous to clk, rising-edge sensitive
- addr  in  5  byte address of register (bits [1:0] ignored)
- wdata  in  32  write data
- we  in  1  write strobe, sampled at posedge clk
- re  in  1  read strobe
- rdata  out  32  read data, combinational; 0 when re=0
- interrupt  out  1  one-cycle request pulse to core

## Operation
- Register map: 0x00 PENDING (R, write-1-to-clear), 0x04 ENABLE (RW), 0x08 MTIME (RW), 0x0C MTIMECMP (RW), 0x10 CLAIM (R claims, W completes). Unmapped addresses read 0, writes ignored.
- PENDING/ENABLE are NUM_SRC+1 bits wide, zero-extended on read, upper wdata bits ignored. Bit i<NUM_SRC is external source i; bit NUM_SRC is timer.
- Edge detect: registered copy src_q of irq_src; pending[i] set when irq_src[i]=1 and src_q[i]=0.
- Timer: MTIME increments by 1 every cycle, wraps 0xFFFF_FFFF->0. pending[NUM_SRC] set in the cycle when MTIME==MTIMECMP (registered compare). A write to MTIME loads wdata instead of incrementing that cycle.
- Same-cycle set and W1C clear on one bit: set wins.
- CLAIM read: returns lowest index i with pending[i]&enable[i] (ID in [4:0], upper bits 0); at the clock edge with re=1 that bit is cleared. With none active, it returns 0xFFFF_FFFF and has no side effect.
- FSM states IDLE, FIRE, WAIT:
  - IDLE: if |(pending&enable) -> FIRE.
  - FIRE: interrupt=1 for exactly this cycle -> WAIT.
  - WAIT: interrupt=0; a write to CLAIM (any data) -> IDLE. New pendings only latch here; no pulse.
- interrupt is the registered decode of state==FIRE, so it is glitch-free.

## Timing
- Reset values: interrupt=0, state=IDLE, PENDING=0, ENABLE=0, MTIME=0, MTIMECMP=0xFFFF_FFFF, src_q=0. rdata=0 while re=0.
- Reset is asynchronous. Asserting it mid-operation, including during FIRE, forces all of the above immediately. The pulse is truncated.
- Latency:
  - Source rising edge at cycle N sets pending at N+1.
  - With the source enabled and state IDLE, FSM enters FIRE at N+2, so interrupt is high during cycle N+2.
- Timer: MTIME reaches MTIMECMP in cycle T. Pending is set at T+1, and interrupt is high at T+2 if enabled and idle.
- Complete-write in cycle C returns to IDLE at C+1. If pending&enable is still nonzero, interrupt pulses again at C+2.
- Enabling an already-pending source while IDLE fires 2 cycles after the ENABLE write edge. Minimum spacing between pulses is 3 cycles.
- Reads are same-cycle combinational. Claim side effect takes effect at that cycle's posedge.

## Test plan
- Reset: hold reset 3 cycles -> interrupt=0, PENDING read 0, MTIMECMP read 0xFFFF_FFFF. Deassert -> MTIME reads 1 after one cycle.
- External source: ENABLE=0x1, pulse irq_src[0] high 1 cycle -> interrupt high exactly one cycle, 2 cycles later. CLAIM read returns 0 and PENDING becomes 0. Write CLAIM -> no further pulse.
- Priority and masking: ENABLE=0x6, edges on sources 1,2,3 same cycle -> one pulse. CLAIM reads 1, then 2, then 0xFFFF_FFFF. PENDING retains bit 3.
- Timer: write MTIME=0, MTIMECMP=10, ENABLE=0x10 -> pending[4] set at cycle 11 after write, pulse at 12. CLAIM returns 4.
- Hold-off: in WAIT, new edge on enabled source 0 -> no pulse. Write CLAIM -> pulse 2 cycles later.
- Simultaneous W1C of bit 0 with edge on source 0 -> bit 0 remains set. Wrap: MTIME=0xFFFF_FFFF -> next read 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the pipelined core.
//
// Edge-detects NUM_SRC external request lines, runs a free-running machine
// timer with a compare register, and latches pending requests. Pending and
// enabled requests raise a one-cycle `interrupt` pulse. Further pulses are
// held off until software writes CLAIM to complete the handled request.
//
// Ports:
//   clk        core clock
//   reset      asynchronous, active-high reset
//   irq_src    external request lines (rising-edge sensitive, clk-synchronous)
//   addr       byte address of register (bits [1:0] ignored)
//   wdata      write data
//   we         write strobe
//   re         read strobe
//   rdata      combinational read data, 0 when re=0
//   interrupt  one-cycle request pulse to the core
//
// Register map (word index = addr[4:2]):
//   0 PENDING  (R, write-1-to-clear)    1 ENABLE  (RW)
//   2 MTIME    (RW)                     3 MTIMECMP (RW)
//   4 CLAIM    (read claims lowest active ID, write completes)
module irq_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  input  logic               we,
  input  logic               re,
  output logic [31:0]        rdata,
  output logic               interrupt
);

  localparam int NW = NUM_SRC + 1;  // external sources plus the timer

  localparam logic [2:0] SEL_PENDING  = 3'd0;
  localparam logic [2:0] SEL_ENABLE   = 3'd1;
  localparam logic [2:0] SEL_MTIME    = 3'd2;
  localparam logic [2:0] SEL_MTIMECMP = 3'd3;
  localparam logic [2:0] SEL_CLAIM    = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               interrupt_reg;
  logic [NUM_SRC-1:0] src_q_reg;
  logic [NW-1:0]      pending_reg, pending_next;
  logic [NW-1:0]      enable_reg;
  logic [31:0]        mtime_reg, mtimecmp_reg;

  logic [2:0]         reg_sel;
  logic               wr_pending, wr_enable, wr_mtime, wr_mtimecmp, wr_claim, rd_claim;
  logic [NW-1:0]      set_vec;
  logic [NW-1:0]      active;
  logic               claim_found;
  logic [4:0]         claim_id;
  logic [NW-1:0]      claim_onehot;
  logic               unused_addr_bits;

  assign reg_sel          = addr[4:2];
  assign unused_addr_bits = ^addr[1:0];

  assign wr_pending  = we && (reg_sel == SEL_PENDING);
  assign wr_enable   = we && (reg_sel == SEL_ENABLE);
  assign wr_mtime    = we && (reg_sel == SEL_MTIME);
  assign wr_mtimecmp = we && (reg_sel == SEL_MTIMECMP);
  assign wr_claim    = we && (reg_sel == SEL_CLAIM);
  assign rd_claim    = re && (reg_sel == SEL_CLAIM);

  // Set requests: one rising-edge detector per external line, plus the timer
  // match on the registered MTIME/MTIMECMP values.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_edge
      assign set_vec[gi] = irq_src[gi] & ~src_q_reg[gi];
    end
  endgenerate
  assign set_vec[NUM_SRC] = (mtime_reg == mtimecmp_reg);

  assign active = pending_reg & enable_reg;

  // Lowest-index active request. Scanning from the top down lets the last
  // hit (the lowest index) overwrite any earlier one.
  always_comb begin
    claim_found  = 1'b0;
    claim_id     = '0;
    claim_onehot = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_found     = 1'b1;
        claim_id        = 5'(i);
        claim_onehot    = '0;
        claim_onehot[i] = 1'b1;
      end
    end
  end

  // Clears are applied first so a same-cycle set always wins.
  always_comb begin
    pending_next = pending_reg;
    if (wr_pending) begin
      pending_next = pending_next & ~wdata[NW-1:0];
    end
    if (rd_claim && claim_found) begin
      pending_next = pending_next & ~claim_onehot;
    end
    pending_next = pending_next | set_vec;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|active) state_next = FIRE;
      FIRE:    state_next = WAIT;
      WAIT:    if (wr_claim) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // interrupt is registered from the next-state decode, so it is high for
  // exactly the cycle the FSM spends in FIRE and cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      interrupt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      interrupt_reg <= (state_next == FIRE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q_reg    <= '0;
      pending_reg  <= '0;
      enable_reg   <= '0;
      mtime_reg    <= '0;
      mtimecmp_reg <= 32'hFFFF_FFFF;
    end else begin
      src_q_reg   <= irq_src;
      pending_reg <= pending_next;
      if (wr_enable) begin
        enable_reg <= wdata[NW-1:0];
      end
      // A software load replaces the increment for that cycle.
      mtime_reg <= wr_mtime ? wdata : mtime_reg + 32'd1;
      if (wr_mtimecmp) begin
        mtimecmp_reg <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (re) begin
      case (reg_sel)
        SEL_PENDING:  rdata = 32'(pending_reg);
        SEL_ENABLE:   rdata = 32'(enable_reg);
        SEL_MTIME:    rdata = mtime_reg;
        SEL_MTIMECMP: rdata = mtimecmp_reg;
        SEL_CLAIM:    rdata = claim_found ? 32'(claim_id) : 32'hFFFF_FFFF;
        default:      rdata = '0;
      endcase
    end
  end

  assign interrupt = interrupt_reg;

endmodule
